// File: rtl/filter_bank_2018.sv
`default_nettype none
// ============================================================================
// Module   : filter_bank_2018
// Brief    : NUM_CH boxcar moving-sum filters with per-channel threshold peak
//            detectors, merged into one valid/ready event stream through a
//            round-robin arbiter. Optional macro FILTER_BANK_TIMESTAMP_EN
//            enables the timestamp counter (event_time is 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module filter_bank_2018 #(
    parameter int SIZE_ADC_DATA    = 12,
    parameter int SIZE_FILTER_DATA = 20,
    parameter int NUM_CH           = 4,
    parameter int MAX_WIN          = 16,
    parameter int SIZE_TIME        = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CH*SIZE_ADC_DATA-1:0]    input_data,
    input  logic [$clog2(MAX_WIN):0]           win_len,
    input  logic [SIZE_FILTER_DATA-1:0]        threshold,
    output logic [NUM_CH*SIZE_FILTER_DATA-1:0] output_data,
    output logic                               event_valid,
    input  logic                               event_ready,
    output logic [$clog2(NUM_CH)-1:0]          event_channel,
    output logic [SIZE_FILTER_DATA-1:0]        event_peak,
    output logic [SIZE_TIME-1:0]               event_time,
    output logic [15:0]                        drop_count
);

    localparam int c_LW = $clog2(MAX_WIN);
    localparam int c_WW = c_LW + 1;
    localparam int c_CW = $clog2(NUM_CH);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_ARMED = 1'b1;

    // ------------------------------------------------------------------
    // Window latch and effective length
    // ------------------------------------------------------------------
    logic [c_WW-1:0] r_win_len;
    logic [c_WW-1:0] w_len;
    logic [c_LW-1:0] w_tap;
    logic            w_win_chg;

    assign w_win_chg = (win_len != r_win_len);

    always_comb begin
        w_len = r_win_len;
        if (r_win_len == '0) begin
            w_len = c_WW'(1);
        end else if (r_win_len > c_WW'(MAX_WIN)) begin
            w_len = c_WW'(MAX_WIN);
        end
    end

    // Tap L-1 of the delay line holds x[n-L].
    assign w_tap = c_LW'(w_len - c_WW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_len <= '0;
        end else if (w_win_chg) begin
            r_win_len <= win_len;
        end
    end

    // ------------------------------------------------------------------
    // Timestamp
    // ------------------------------------------------------------------
    logic [SIZE_TIME-1:0] w_time;

`ifdef FILTER_BANK_TIMESTAMP_EN
    logic [SIZE_TIME-1:0] r_time;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_time <= '0;
        end else begin
            r_time <= r_time + SIZE_TIME'(1);
        end
    end

    assign w_time = r_time;
`else
    assign w_time = '0;
`endif

    // ------------------------------------------------------------------
    // Per-channel filter and detector
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]           w_emit;
    logic [NUM_CH-1:0]           w_drop;
    logic [NUM_CH-1:0]           w_grant;
    logic [NUM_CH-1:0]           r_pend;
    logic [SIZE_FILTER_DATA-1:0] w_cur_peak  [NUM_CH];
    logic [SIZE_TIME-1:0]        w_cur_tpk   [NUM_CH];
    logic [SIZE_FILTER_DATA-1:0] r_pend_peak [NUM_CH];
    logic [SIZE_TIME-1:0]        r_pend_time [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SIZE_ADC_DATA-1:0]    w_x;
        logic [SIZE_ADC_DATA-1:0]    r_dl [MAX_WIN];
        logic [SIZE_FILTER_DATA-1:0] r_sum;
        logic [SIZE_FILTER_DATA-1:0] r_peak;
        logic [SIZE_TIME-1:0]        r_tpk;
        logic [0:0]                  r_state;

        assign w_x = input_data[g*SIZE_ADC_DATA +: SIZE_ADC_DATA];
        assign output_data[g*SIZE_FILTER_DATA +: SIZE_FILTER_DATA] = r_sum;
        assign w_cur_peak[g] = r_peak;
        assign w_cur_tpk[g]  = r_tpk;

        // A window change forces IDLE, so it must also suppress emission.
        assign w_emit[g] = !w_win_chg && (r_state == c_ST_ARMED) && (r_sum <= threshold);
        assign w_drop[g] = w_emit[g] && r_pend[g] && !w_grant[g];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sum <= '0;
                for (int i = 0; i < MAX_WIN; i++) begin
                    r_dl[i] <= '0;
                end
            end else if (w_win_chg) begin
                r_sum <= '0;
                for (int i = 0; i < MAX_WIN; i++) begin
                    r_dl[i] <= '0;
                end
            end else begin
                r_sum <= r_sum + SIZE_FILTER_DATA'(w_x) - SIZE_FILTER_DATA'(r_dl[w_tap]);
                r_dl[0] <= w_x;
                for (int i = 1; i < MAX_WIN; i++) begin
                    r_dl[i] <= r_dl[i-1];
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= c_ST_IDLE;
                r_peak  <= '0;
                r_tpk   <= '0;
            end else if (w_win_chg) begin
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (r_sum > threshold) begin
                            r_state <= c_ST_ARMED;
                            r_peak  <= r_sum;
                            r_tpk   <= w_time;
                        end
                    end
                    c_ST_ARMED: begin
                        if (r_sum <= threshold) begin
                            r_state <= c_ST_IDLE;
                        end else if (r_sum > r_peak) begin
                            r_peak <= r_sum;
                            r_tpk  <= w_time;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending slots
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pend_peak[i] <= '0;
                r_pend_time[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // A slot freed by a grant on this edge may take the new event.
                if (w_emit[i] && (!r_pend[i] || w_grant[i])) begin
                    r_pend[i]      <= 1'b1;
                    r_pend_peak[i] <= w_cur_peak[i];
                    r_pend_time[i] <= w_cur_tpk[i];
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter and output register
    // ------------------------------------------------------------------
    logic [c_CW-1:0] r_ptr;
    logic [c_CW-1:0] w_sel;
    logic [c_CW-1:0] w_idx;
    logic            w_found;
    logic            w_load;

    assign w_load = !event_valid || event_ready;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        w_grant = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = c_CW'((int'(r_ptr) + i) % NUM_CH);
            if (!w_found && r_pend[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        if (w_load && w_found) begin
            w_grant[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_valid   <= 1'b0;
            event_channel <= '0;
            event_peak    <= '0;
            event_time    <= '0;
            r_ptr         <= c_CW'(NUM_CH - 1);
        end else if (w_load) begin
            event_valid <= w_found;
            if (w_found) begin
                event_channel <= w_sel;
                event_peak    <= r_pend_peak[w_sel];
                event_time    <= r_pend_time[w_sel];
                r_ptr         <= w_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop counter (several channels may drop on the same edge)
    // ------------------------------------------------------------------
    logic [16:0] w_drop_sum;

    always_comb begin
        w_drop_sum = {1'b0, drop_count};
        for (int i = 0; i < NUM_CH; i++) begin
            w_drop_sum = w_drop_sum + 17'(w_drop[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else begin
            drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

endmodule
`default_nettype wire

// File: doc/filter_bank_2018.md
# filter_bank_2018

Parametrised multi-channel successor to the fixed v1..v8 filter top. Runs NUM_CH boxcar (moving-sum) shaping filters with a runtime-programmable window. Each channel has a threshold peak detector, and detected pulses are merged into a single valid/ready event stream through a round-robin arbiter. It sits directly behind exp_sig_gen or the ADC front end and replaces the per-variant filter instances.

## Interface
Parameters:
- SIZE_ADC_DATA, 12, input sample width (unsigned)
- SIZE_FILTER_DATA, 20, filter output width; must be ≥ SIZE_ADC_DATA + log2(MAX_WIN)
- NUM_CH, 4, channel count (2..16)
- MAX_WIN, 16, maximum window length, power of two
- SIZE_TIME, 16, timestamp width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- input_data  in  NUM_CH*SIZE_ADC_DATA  one sample per channel per clock; channel i is at slice i
- win_len  in  $clog2(MAX_WIN)+1  window length; shared by all channels
- threshold  in  SIZE_FILTER_DATA  detection threshold; shared by all channels
- output_data  out  NUM_CH*SIZE_FILTER_DATA  filtered streams
- event_valid  out  1  event word available
- event_ready  in  1  consumer accepts
- event_channel  out  $clog2(NUM_CH)  source channel
- event_peak  out  SIZE_FILTER_DATA  pulse maximum
- event_time  out  SIZE_TIME  timestamp of maximum
- drop_count  out  16  saturating count of lost events

## Operation
- Effective window: L = clamp(win_len, 1, MAX_WIN).
- Filter, per channel:
  - Delay line is MAX_WIN deep.
  - sum <= sum + x[n] − x[n−L], which equals the sum of the last L samples.
  - The arithmetic is unsigned and never overflows, given the width rule.
- Window change: if win_len differs from the latched value, the next edge does all of the following:
  - latches the new value;
  - zeroes every delay line and every sum;
  - forces every detector to IDLE with no emission.
  - Pending events survive.
- Detector FSM, per channel:
  - IDLE: if y > threshold, go to ARMED; peak<=y, tpk<=timestamp.
  - ARMED: if y > peak, update peak and tpk. If y ≤ threshold, emit and return to IDLE. Equality with threshold counts as below.
- Emit: set pending[ch] and latch {peak, tpk}.
  - If pending[ch] is already set and not being granted on the same edge, the new event is dropped and drop_count increments (saturates at 16'hFFFF).
  - If a grant clears pending[ch] on the same edge as an emit, the new event is stored and nothing is dropped.
- Arbiter:
  - Loads the output register when event_valid=0, or when event_valid=1 and event_ready=1.
  - Scans round-robin starting from the channel after the last one granted, and takes the first channel with pending set.
  - Clears that channel's pending bit on the load edge.
- Output register: event fields hold stable while event_valid=1 and event_ready=0.
- Timestamp: free-running SIZE_TIME counter that wraps modulo 2^SIZE_TIME.

## Timing
- Reset values: all outputs 0, including event_valid=0 and drop_count=0. Delay lines, sums, pending bits and timestamp are 0; detectors are IDLE; the round-robin pointer is at channel NUM_CH−1, so the first grant goes to channel 0.
- Reset may assert mid-operation, including while event_valid=1. It clears immediately and the event is lost.
- A sample presented before edge t appears in output_data after edge t (1-cycle latency).
- The detector evaluates the registered y. A falling crossing visible after edge t sets pending at edge t+1.
- event_valid rises at edge t+2 if the output register is free.
- Throughput: one event per clock when event_ready stays high.

## Configuration
- FILTER_BANK_TIMESTAMP_EN defined: timestamp counter is present, and event_time carries the cycle count of the peak.
- Undefined: no counter is synthesised, and event_time is tied to 0. All other behaviour is identical.

## Test plan
- Constant input 100 on channel 0, win_len=4: output_data ch0 reads 100, 200, 300, 400, then holds 400; no event while threshold=1000.
- win_len=0 and win_len=31 with MAX_WIN=16: behaves as L=1 and L=16 (step 10 settles to 10 and 160).
- Single pulse ch2, peak filtered value 900, threshold=500, event_ready=1: exactly one event {ch=2, peak=900, time=cycle of max}; event_valid rises 2 cycles after y ≤ 500.
- Simultaneous pulses on all 4 channels, event_ready=0 for 20 cycles then 1: events delivered in order 0, 1, 2, 3; fields stable while stalled; drop_count=0.
- Second pulse on ch1 while its first is still pending under stall: drop_count=1; the first event is still delivered intact.
- win_len change mid-pulse with the detector ARMED: sums and output_data go to 0 on the next edge and no event is emitted. Assert reset while event_valid=1: all outputs 0 at once.
